// File: rtl/display_sched_pkg.sv
// Shared types and constants for the display_scheduler slice.
package display_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHOW_MEAS,
        SHOW_USER
    } state_t;

    localparam logic SRC_MEAS = 1'b0;
    localparam logic SRC_USER = 1'b1;

    localparam int unsigned FREQ_W_DEF = 13;

endpackage

// File: rtl/display_scheduler_tick_divider.sv
// tick_divider: free-running modulo-DIV counter, counts only while en is high.
// tick is high during the enabled cycle in which the counter wraps back to 0.
module tick_divider #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/display_scheduler.sv
// display_scheduler: shares the frequency display between rate-limited meas and dwell-timed user values.
// Optional DISPLAY_HOLD_EN adds hold_in, which freezes handshakes, counters and outputs.
module display_scheduler
    import display_sched_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned REFRESH_HZ  = 4,
    parameter int unsigned DWELL_MS    = 1000,
    parameter int unsigned FREQ_W      = FREQ_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              meas_valid,
    output logic              meas_ready,
    input  logic [FREQ_W-1:0] meas_freq,
    input  logic [1:0]        meas_scale,
    input  logic              user_valid,
    output logic              user_ready,
    input  logic [FREQ_W-1:0] user_freq,
    input  logic [1:0]        user_scale,
`ifdef DISPLAY_HOLD_EN
    input  logic              hold_in,
`endif
    output logic [FREQ_W-1:0] frequency_out,
    output logic [1:0]        scale_out,
    output logic              src_out,
    output logic              update_pulse
);

    localparam int unsigned REFRESH_CYC = CLK_FREQ_HZ / REFRESH_HZ;
    localparam int unsigned DWELL_CYC   = (CLK_FREQ_HZ / 1000) * DWELL_MS;
    localparam int unsigned DW          = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYC - 1);

    state_t        state;
    logic          ref_pending;
    logic          refresh_tick;
    logic          refresh_en;
    logic [DW-1:0] dwell_cnt;
    logic          changed;
    logic          hold;
    logic          meas_acc;
    logic          user_acc;

`ifdef DISPLAY_HOLD_EN
    assign hold = hold_in;
`else
    assign hold = 1'b0;
`endif

    // User always wins: meas_ready drops whenever a user value is on offer.
    always_comb begin
        user_ready = (state != IDLE) && !hold;
        meas_ready = (state == SHOW_MEAS) && ref_pending && !hold && !user_valid;
        user_acc   = user_valid && user_ready;
        meas_acc   = meas_valid && meas_ready;
        refresh_en = (state == SHOW_MEAS) && !hold;
    end

    tick_divider #(
        .DIV (REFRESH_CYC)
    ) u_refresh (
        .clk   (clk),
        .reset (reset),
        .en    (refresh_en),
        .tick  (refresh_tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            ref_pending   <= 1'b0;
            dwell_cnt     <= '0;
            frequency_out <= '0;
            scale_out     <= '0;
            src_out       <= SRC_MEAS;
            changed       <= 1'b0;
            update_pulse  <= 1'b0;
        end else begin
            changed      <= meas_acc || user_acc;
            update_pulse <= changed;
            if (!hold) begin
                case (state)
                    IDLE: state <= SHOW_MEAS;
                    SHOW_MEAS: begin
                        if (user_acc) begin
                            frequency_out <= user_freq;
                            scale_out     <= user_scale;
                            src_out       <= SRC_USER;
                            dwell_cnt     <= '0;
                            state         <= SHOW_USER;
                        end else if (meas_acc) begin
                            frequency_out <= meas_freq;
                            scale_out     <= meas_scale;
                            src_out       <= SRC_MEAS;
                        end
                        // A tick landing on an accept re-arms the flag for the next sample.
                        if (refresh_tick) begin
                            ref_pending <= 1'b1;
                        end else if (meas_acc) begin
                            ref_pending <= 1'b0;
                        end
                    end
                    SHOW_USER: begin
                        if (user_acc) begin
                            frequency_out <= user_freq;
                            scale_out     <= user_scale;
                            src_out       <= SRC_USER;
                            dwell_cnt     <= '0;
                        end else if (dwell_cnt == DWELL_LAST) begin
                            state       <= SHOW_MEAS;
                            ref_pending <= 1'b1;
                        end else begin
                            dwell_cnt <= dwell_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
